// File: rtl/poly_round_pack_pkg.sv
// Shared Saber constants and FSM state type for the multiplier result unloader.
package poly_round_pack_pkg;

  localparam int SABER_N   = 256;
  localparam int SABER_EQ  = 13;
  localparam int SABER_EP  = 10;
  localparam int WORDS_RAW = SABER_N * SABER_EQ / 64;  // 52
  localparam int WORDS_RND = SABER_N * SABER_EP / 64;  // 40

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/poly_round_pack_if.sv
// Control, beat-input and packed-output signals of the unloader in one bundle.
interface poly_round_pack_if #(
  parameter int W = 64
);
  logic         start;
  logic         round_en;
  logic         mul_read;
  logic         in_valid;
  logic [W-1:0] coeff4x_in;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic [5:0]   out_addr;
  logic         busy;
  logic         done;

  modport slave (
    input  start, round_en, in_valid, coeff4x_in,
    output mul_read, out_word, out_valid, out_addr, busy, done
  );

  modport master (
    output start, round_en, in_valid, coeff4x_in,
    input  mul_read, out_word, out_valid, out_addr, busy, done
  );
endinterface

// File: rtl/poly_round_pack_round4.sv
// Combinational 4-lane q->p rounding / raw truncation of one multiplier beat.
module saber_round4
  import poly_round_pack_pkg::*;
#(
  parameter int EQ = SABER_EQ,
  parameter int EP = SABER_EP,
  parameter int W  = 64
) (
  input  logic [W-1:0]    beat_i,
  input  logic            round_en_i,
  output logic [4*EQ-1:0] lanes_o
);

  localparam int LANE_W = W / 4;

  // Adding half an output LSB then dropping the carry gives round-half-up with wrap.
  function automatic logic [EP-1:0] round_q2p(input logic [EQ-1:0] c);
    logic [EQ:0] s;
    s = {1'b0, c} + (EQ+1)'(1 << (EQ - EP - 1));
    return s[EQ-1:EQ-EP];
  endfunction

  logic unused_hi;

  always_comb begin
    lanes_o   = '0;
    unused_hi = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (round_en_i)
        lanes_o[EP*k +: EP] = round_q2p(beat_i[LANE_W*k +: EQ]);
      else
        lanes_o[EQ*k +: EQ] = beat_i[LANE_W*k +: EQ];
      unused_hi = unused_hi ^ (^beat_i[LANE_W*k+EQ +: (LANE_W-EQ)]);
    end
  end

endmodule

// File: rtl/poly_round_pack.sv
// Unloads a polynomial from the multiplier, optionally rounds q->p and bit-packs
// the coefficients LSB-first into dense 64-bit words for BRAM write-back.
module poly_round_pack
  import poly_round_pack_pkg::*;
#(
  parameter int N_COEFF = SABER_N,
  parameter int EQ      = SABER_EQ,
  parameter int EP      = SABER_EP,
  parameter int W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  poly_round_pack_if.slave bus
);

  localparam int BEATS  = N_COEFF / 4;
  localparam int BC_W   = $clog2(BEATS);
  localparam int BUF_W  = 2 * W;
  localparam int FILL_W = $clog2(BUF_W);

  state_e            state_q, state_d;
  logic              round_q, round_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [5:0]        word_q, word_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [W-1:0]      out_word_q, out_word_d;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        out_addr_q, out_addr_d;
  logic              done_q, done_d;

  logic [4*EQ-1:0]   lanes;
  logic [4*EQ-1:0]   beat_bits;
  logic [FILL_W-1:0] beat_nbits;
  logic [FILL_W-1:0] fill_sum;
  logic [BUF_W-1:0]  merged;

  saber_round4 #(.EQ(EQ), .EP(EP), .W(W)) u_round4 (
    .beat_i     (bus.coeff4x_in),
    .round_en_i (round_q),
    .lanes_o    (lanes)
  );

  // New beat lands directly above the bits already waiting in the buffer.
  always_comb begin
    beat_bits  = round_q ? {{(4*(EQ-EP)){1'b0}}, lanes[4*EP-1:0]} : lanes;
    beat_nbits = round_q ? FILL_W'(4*EP) : FILL_W'(4*EQ);
    fill_sum   = fill_q + beat_nbits;
    merged     = buf_q | ({{(BUF_W-4*EQ){1'b0}}, beat_bits} << fill_q);
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    beat_d      = beat_q;
    word_d      = word_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          round_d = bus.round_en;
          beat_d  = '0;
          word_d  = '0;
          buf_d   = '0;
          fill_d  = '0;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          beat_d = beat_q + 1'b1;
          buf_d  = merged;
          fill_d = fill_sum;
          if (fill_sum >= FILL_W'(W)) begin
            out_word_d  = merged[W-1:0];
            out_valid_d = 1'b1;
            out_addr_d  = word_q;
            word_d      = word_q + 1'b1;
            buf_d       = merged >> W;
            fill_d      = fill_sum - FILL_W'(W);
          end
          if (beat_q == BC_W'(BEATS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      round_q     <= 1'b0;
      beat_q      <= '0;
      word_q      <= '0;
      buf_q       <= '0;
      fill_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  assign bus.mul_read  = (state_q == RUN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_word  = out_word_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_poly_round_pack.sv
// Bench for poly_round_pack: software packer model versus the DUT word stream.
module tb_poly_round_pack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  poly_round_pack_if #(.W(64)) ifc ();

  poly_round_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  int unsigned lane_v [256];
  logic [63:0] exp_w [$];
  logic [63:0] got_w [$];
  int          got_a [$];
  bit          got_d [$];
  logic [63:0] saved_w [$];

  always @(posedge clk) begin
    #1;
    if (ifc.out_valid === 1'b1) begin
      got_w.push_back(ifc.out_word);
      got_a.push_back(int'(ifc.out_addr));
      got_d.push_back(ifc.done);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: list of coefficient values laid end to end, cut into 64-bit words.
  task automatic build_expected(input bit mode);
    logic [3327:0] stream;
    int b, nw;
    int unsigned c, v;
    b = mode ? 10 : 13;
    stream = '0;
    for (int i = 0; i < 256; i++) begin
      c = lane_v[i] % 8192;
      v = mode ? ((c + 4) / 8) % 1024 : c;
      for (int k = 0; k < b; k++) stream[i*b + k] = v[k];
    end
    nw = 256 * b / 64;
    exp_w.delete();
    for (int j = 0; j < nw; j++) exp_w.push_back(stream[j*64 +: 64]);
  endtask

  task automatic drive_beat(input int b);
    ifc.in_valid   = 1'b1;
    ifc.coeff4x_in = {lane_v[4*b+3][15:0], lane_v[4*b+2][15:0],
                      lane_v[4*b+1][15:0], lane_v[4*b][15:0]};
  endtask

  // gaps: 0 none, 1 idle every 3rd cycle, 2 random idles
  task automatic run_poly(input bit mode, input int gaps, input bit inject);
    int cyc;
    int nd;
    build_expected(mode);
    @(negedge clk);
    chk("idle_busy", 64'(ifc.busy), 64'd0);
    got_w.delete(); got_a.delete(); got_d.delete();
    ifc.start    = 1'b1;
    ifc.round_en = mode;
    @(negedge clk);
    ifc.start    = 1'b0;
    ifc.round_en = ~mode;
    chk("run_busy", 64'(ifc.busy), 64'd1);
    cyc = 0;
    for (int b = 0; b < 64; b++) begin
      if ((gaps == 1 && (cyc % 3) == 2) || (gaps == 2 && $urandom_range(0, 3) == 0)) begin
        ifc.in_valid   = 1'b0;
        ifc.coeff4x_in = {$urandom, $urandom};
        @(negedge clk);
        cyc++;
        chk("gap_mul_read", 64'(ifc.mul_read), 64'd1);
      end
      drive_beat(b);
      if (inject && b == 10) ifc.start = 1'b1;
      @(negedge clk);
      cyc++;
      ifc.start    = 1'b0;
      ifc.in_valid = 1'b0;
      if (b < 63) chk("mul_read", 64'(ifc.mul_read), 64'd1);
    end
    chk("done_pulse", 64'(ifc.done), 64'd1);
    chk("last_valid", 64'(ifc.out_valid), 64'd1);
    chk("done_mul_read", 64'(ifc.mul_read), 64'd0);
    chk("done_busy", 64'(ifc.busy), 64'd1);
    chk("nwords", 64'(got_w.size()), 64'(exp_w.size()));
    nd = 0;
    for (int j = 0; j < got_w.size() && j < exp_w.size(); j++) begin
      chk($sformatf("word%0d", j), got_w[j], exp_w[j]);
      chk($sformatf("addr%0d", j), 64'(got_a[j]), 64'(j));
      if (got_d[j]) nd++;
    end
    chk("done_count", 64'(nd), 64'd1);
    chk("done_on_last", 64'(got_d.size() > 0 ? got_d[got_d.size()-1] : 1'b0), 64'd1);
  endtask

  initial begin
    ifc.start      = 1'b0;
    ifc.round_en   = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.coeff4x_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_word", ifc.out_word, 64'd0);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_addr", 64'(ifc.out_addr), 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_done", 64'(ifc.done), 64'd0);
    chk("rst_mul_read", 64'(ifc.mul_read), 64'd0);
    rst = 1'b1;
    // in_valid while idle must not start anything
    ifc.in_valid = 1'b1; ifc.coeff4x_in = {$urandom, $urandom};
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("idle_ignore", 64'(ifc.busy), 64'd0);

    // Raw mode, all ones
    for (int i = 0; i < 256; i++) lane_v[i] = 32'h1FFF;
    run_poly(1'b0, 0, 1'b0);
    for (int j = 0; j < got_w.size(); j++)
      if (j == 0 || j == 51) chk($sformatf("ones%0d", j), got_w[j], 64'hFFFF_FFFF_FFFF_FFFF);

    // Rounded mode, every r = 1
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) lane_v[i] = 32'd4;
    run_poly(1'b1, 0, 1'b0);
    chk("r1_word0", got_w.size() > 0 ? got_w[0] : 64'hx, 64'h1004_0100_4010_0401);

    // Wrap and round-half-up corners, garbage in unused lane bits
    for (int b = 0; b < 64; b++) begin
      lane_v[4*b]   = 32'hE000 | 32'd8191;
      lane_v[4*b+1] = 32'hA000 | 32'd8188;
      lane_v[4*b+2] = 32'd8187;
      lane_v[4*b+3] = 32'h6000 | 32'd12;
    end
    run_poly(1'b1, 0, 1'b0);
    chk("wrap_word0", got_w.size() > 0 ? got_w[0] : 64'hx, 64'hF000_0000_BFF0_0000);

    // Ramp, gap-free then with every third cycle idle
    for (int i = 0; i < 256; i++) lane_v[i] = i % 8192;
    run_poly(1'b1, 0, 1'b0);
    saved_w = got_w;
    run_poly(1'b1, 1, 1'b0);
    chk("gap_same_size", 64'(got_w.size()), 64'(saved_w.size()));
    for (int j = 0; j < got_w.size() && j < saved_w.size(); j++)
      chk($sformatf("gap_same%0d", j), got_w[j], saved_w[j]);

    // Random data, both modes, random stalls
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 256; i++) lane_v[i] = $urandom_range(0, 65535);
      run_poly(t[0], 2, 1'b0);
    end

    // Reset in the middle of an unload
    for (int i = 0; i < 256; i++) lane_v[i] = $urandom_range(0, 65535);
    @(negedge clk);
    ifc.start = 1'b1; ifc.round_en = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int b = 0; b < 21; b++) begin
      drive_beat(b);
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_word", ifc.out_word, 64'd0);
    chk("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("mid_rst_out_addr", 64'(ifc.out_addr), 64'd0);
    chk("mid_rst_busy", 64'(ifc.busy), 64'd0);
    chk("mid_rst_mul_read", 64'(ifc.mul_read), 64'd0);
    chk("mid_rst_done", 64'(ifc.done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_poly(1'b1, 0, 1'b0);

    // Start during RUN ignored, then back-to-back start right after done
    for (int i = 0; i < 256; i++) lane_v[i] = $urandom_range(0, 65535);
    run_poly(1'b0, 0, 1'b1);
    for (int i = 0; i < 256; i++) lane_v[i] = $urandom_range(0, 65535);
    run_poly(1'b1, 0, 1'b0);

    @(negedge clk);
    chk("final_idle", 64'(ifc.busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
